// File: rtl/generador_entradas.sv
// -----------------------------------------------------------------------------
// generador_entradas
//
// Stimulus stage for the two-input logic-gate block. Raw board switches are
// synchronised (two flops) and debounced, then drive a registered operand
// pair {entradaA, entradaB}.
//   MANUAL : operands follow the debounced switches.
//   AUTO   : operands sweep 00 -> 01 -> 10 -> 11 -> 00 ..., each row held for
//            DWELL_CYCLES clocks; switches keep being debounced but are unused.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   sw_a       in   raw switch, operand A (asynchronous, bouncy)
//   sw_b       in   raw switch, operand B (asynchronous, bouncy)
//   modo_auto  in   raw mode switch, 1 = AUTO
//   entradaA   out  registered operand A
//   entradaB   out  registered operand B
//   indice     out  current row {entradaA, entradaB}; sweep counter in AUTO
//   modo       out  current state, 1 = AUTO
//   cambio     out  one-cycle pulse while a newly changed operand pair is shown
// -----------------------------------------------------------------------------
module generador_entradas #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_a,
  input  logic       sw_b,
  input  logic       modo_auto,
  output logic       entradaA,
  output logic       entradaB,
  output logic [1:0] indice,
  output logic       modo,
  output logic       cambio
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;

  // Bit 0 = sw_a, bit 1 = sw_b, bit 2 = modo_auto.
  logic [2:0] raw_in;
  logic [2:0] stable_vec;

  assign raw_in = {modo_auto, sw_b, sw_a};

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer, one identical channel per raw input.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic            s1_q, s1_d;
      logic            s2_q, s2_d;
      logic            stable_q, stable_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d     = raw_in[gi];
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
          // Accept on the cycle the count would reach DEBOUNCE_CYCLES; any
          // return to the stable value before then restarts the count.
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = s2_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q     <= s1_d;
          s2_q     <= s2_d;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign stable_vec[gi] = stable_q;
    end
  endgenerate

  logic stable_a, stable_b, stable_m;

  assign stable_a = stable_vec[0];
  assign stable_b = stable_vec[1];
  assign stable_m = stable_vec[2];

  // ---------------------------------------------------------------------------
  // Mode FSM and operand generation.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         indice_q, indice_d;
  logic               entrada_a_q, entrada_a_d;
  logic               entrada_b_q, entrada_b_d;
  logic               cambio_q, cambio_d;

  always_comb begin
    state_d  = state_q;
    dwell_d  = '0;
    indice_d = indice_q;

    case (state_q)
      MANUAL: begin
        if (stable_m) begin
          // Every entry into AUTO starts the sweep from row 00.
          state_d  = AUTO;
          indice_d = 2'b00;
        end else begin
          indice_d = {stable_a, stable_b};
        end
      end
      AUTO: begin
        if (!stable_m) begin
          // Leaving AUTO takes priority over a coincident dwell terminal count.
          state_d  = MANUAL;
          indice_d = {stable_a, stable_b};
        end else if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
          indice_d = indice_q + 2'd1;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: begin
        state_d = MANUAL;
      end
    endcase

    // The operand pair always equals the row index, in both modes.
    entrada_a_d = indice_d[1];
    entrada_b_d = indice_d[0];
    cambio_d    = ({entrada_a_d, entrada_b_d} != {entrada_a_q, entrada_b_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= MANUAL;
      dwell_q     <= '0;
      indice_q    <= 2'b00;
      entrada_a_q <= 1'b0;
      entrada_b_q <= 1'b0;
      cambio_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      indice_q    <= indice_d;
      entrada_a_q <= entrada_a_d;
      entrada_b_q <= entrada_b_d;
      cambio_q    <= cambio_d;
    end
  end

  assign entradaA = entrada_a_q;
  assign entradaB = entrada_b_q;
  assign indice   = indice_q;
  assign modo     = (state_q == AUTO);
  assign cambio   = cambio_q;

endmodule

// File: tb/tb_generador_entradas.sv
// -----------------------------------------------------------------------------
// tb_generador_entradas
//
// Directed steps following the test plan, then a randomized phase. A
// behavioural model tracks each raw input's sample history (an input is
// accepted once its last DEBOUNCE synchronised samples all disagree with the
// accepted value), and in AUTO derives the row from the time elapsed since
// entry: row = (t / DWELL) mod 4.
// -----------------------------------------------------------------------------
module tb_generador_entradas;

  localparam int DB    = 4;
  localparam int DWELL = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_a, sw_b, modo_auto;
  logic       entradaA, entradaB, modo, cambio;
  logic [1:0] indice;

  int total = 0;
  int bad   = 0;

  generador_entradas #(
    .DEBOUNCE_CYCLES(DB),
    .DWELL_CYCLES   (DWELL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_a     (sw_a),
    .sw_b     (sw_b),
    .modo_auto(modo_auto),
    .entradaA (entradaA),
    .entradaB (entradaB),
    .indice   (indice),
    .modo     (modo),
    .cambio   (cambio)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [7:0] h_a, h_b, h_m;     // h[0] = raw sample at the previous edge
  bit       st_a, st_b, st_m;  // accepted (debounced) values
  bit       m_modo;
  int       t_auto;
  bit [1:0] m_pair;
  bit       m_cambio;

  function automatic bit deb(input bit [7:0] h, input bit st);
    // Synchronised value seen at this edge is the raw sample of two edges ago.
    for (int i = 1; i <= DB; i++) begin
      if (h[i] == st) return st;
    end
    return ~st;
  endfunction

  task model_edge();
    bit       nmodo;
    bit [1:0] np;
    if (!rst_n) begin
      h_a = '0; h_b = '0; h_m = '0;
      st_a = 0; st_b = 0; st_m = 0;
      m_modo = 0; t_auto = 0; m_pair = 2'b00; m_cambio = 0;
    end else begin
      nmodo = st_m;
      if (nmodo) begin
        t_auto = m_modo ? t_auto + 1 : 0;
        np = 2'((t_auto / DWELL) % 4);
      end else begin
        np = {st_a, st_b};
      end
      m_cambio = (np != m_pair);
      m_pair   = np;
      m_modo   = nmodo;
      st_a = deb(h_a, st_a);
      st_b = deb(h_b, st_b);
      st_m = deb(h_m, st_m);
      h_a = {h_a[6:0], sw_a};
      h_b = {h_b[6:0], sw_b};
      h_m = {h_m[6:0], modo_auto};
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs present at the edge, then
  // compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("outs", {2'b00, entradaA, entradaB, indice, modo, cambio},
          {2'b00, m_pair[1], m_pair[0], m_pair, m_modo, m_cambio});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int pulses;
  int hold;

  initial begin
    // ---- reset with all raw inputs high ----
    rst_n = 0; sw_a = 1; sw_b = 1; modo_auto = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", {2'b00, entradaA, entradaB, indice, modo, cambio}, 8'h00);
    end
    rst_n = 1; modo_auto = 0;
    ticks(6);
    check("rst_a_edge6", {7'b0, entradaA}, 8'h00);
    tick();
    check("rst_a_edge7", {7'b0, entradaA}, 8'h01);

    // ---- debounce with 3-cycle glitches ----
    sw_a = 0; sw_b = 0;
    ticks(12);
    pulses = 0;
    for (int g = 0; g < 4; g++) begin
      sw_a = ~sw_a;
      for (int i = 0; i < 3; i++) begin
        tick();
        pulses += int'(cambio);
        check("glitch_a", {7'b0, entradaA}, 8'h00);
      end
    end
    sw_a = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(cambio);
    end
    check("deb_a_edge6", {7'b0, entradaA}, 8'h00);
    tick();
    pulses += int'(cambio);
    check("deb_a_edge7", {7'b0, entradaA}, 8'h01);
    ticks(3);
    pulses += 0;
    check("deb_pulses", 8'(pulses), 8'd1);

    // ---- manual pair 10 -> 11 ----
    check("pair10", {6'b0, indice}, 8'd2);
    sw_b = 1;
    ticks(6);
    check("pair11_early", {6'b0, indice}, 8'd2);
    tick();
    check("pair11", {4'b0, entradaA, entradaB, indice}, 8'b1111);
    check("pair11_cambio", {7'b0, cambio}, 8'h01);

    // ---- AUTO sweep ----
    modo_auto = 1; sw_a = 0; sw_b = 1;
    ticks(6);
    check("auto_pre", {7'b0, modo}, 8'h00);
    tick();
    check("auto_entry", {5'b0, modo, indice}, 8'b100);
    pulses = 0;
    for (int r = 1; r <= 4; r++) begin
      for (int i = 0; i < DWELL; i++) begin
        tick();
        pulses += int'(cambio);
      end
      check("auto_row", {6'b0, indice}, 8'(r % 4));
    end
    check("auto_pulses", 8'(pulses), 8'd4);

    // ---- exit mid-row (row 10, dwell 2), then re-enter ----
    ticks(12);
    check("auto_row10", {6'b0, indice}, 8'd2);
    modo_auto = 0;
    ticks(6);
    check("exit_pre", {7'b0, modo}, 8'h01);
    tick();
    check("exit", {5'b0, modo, entradaA, entradaB}, 8'b001);
    modo_auto = 1;
    ticks(7);
    check("reentry", {5'b0, modo, indice}, 8'b100);
    ticks(4);
    check("reentry_dwell", {6'b0, indice}, 8'd0);
    tick();
    check("reentry_row1", {6'b0, indice}, 8'd1);

    // ---- exit on the same edge as a dwell terminal count ----
    ticks(8);
    modo_auto = 0;
    ticks(7);
    check("exit_tc", {5'b0, modo, indice}, 8'b001);

    // ---- reset in the middle of row 11 ----
    modo_auto = 1;
    ticks(7);
    ticks(16);
    check("auto_row11", {6'b0, indice}, 8'd3);
    rst_n = 0;
    tick();
    check("rst_mid_auto", {2'b00, entradaA, entradaB, indice, modo, cambio}, 8'h00);
    rst_n = 1;
    tick();
    check("rst_no_cambio", {7'b0, cambio}, 8'h00);

    // ---- randomized phase ----
    for (int it = 0; it < 250; it++) begin
      sw_a = 1'($urandom);
      sw_b = 1'($urandom);
      if ($urandom_range(0, 5) == 0) modo_auto = ~modo_auto;
      if ($urandom_range(0, 39) == 0) rst_n = 0;
      hold = (modo_auto) ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 9));
      for (int i = 0; i < hold; i++) begin
        tick();
        rst_n = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/generador_entradas.md
Name: generador_entradas

Overview:
- Upstream stimulus stage for the two-input logic-gate block. Drives its entradaA/entradaB operands.
- Takes raw board switches, synchronises and debounces them, and drives a registered operand pair.
- MANUAL mode: the operands follow the switches.
- AUTO mode: the operands sweep the full truth table 00→01→10→11 with a programmable dwell time, so all gate outputs can be observed hands-free.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a raw input must hold a new value before it is accepted (≥1).
- DWELL_CYCLES, 5, clock cycles each truth-table row is held in AUTO mode (≥2).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- sw_a  input  1  raw switch for operand A; asynchronous, may bounce.
- sw_b  input  1  raw switch for operand B; asynchronous, may bounce.
- modo_auto  input  1  raw mode switch; 1 = AUTO, 0 = MANUAL; debounced like the others.
- entradaA  output  1  registered operand A to the gate stage.
- entradaB  output  1  registered operand B to the gate stage.
- indice  output  2  current truth-table row {entradaA,entradaB}; in AUTO it is the sweep counter.
- modo  output  1  current FSM state (1 = AUTO).
- cambio  output  1  one-cycle pulse, asserted in the cycle after {entradaA,entradaB} changes value.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - entradaA, entradaB, indice, modo and cambio are all 0.
  - Synchroniser flops, debounced values and all counters are 0.
  - FSM state is MANUAL.
  - Reset mid-sweep or mid-debounce discards all progress.
- Synchroniser: each of sw_a, sw_b and modo_auto passes through a 2-flop chain (s1→s2).
- Debounce, per input:
  - Each input has a stable register and a counter of width clog2(DEBOUNCE_CYCLES)+1.
  - If s2==stable: counter cleared.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, stable takes s2 and the counter clears.
  - Result: a raw change held steady is accepted into stable at the (DEBOUNCE_CYCLES+2)th edge after it settles.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches stable.
- FSM states and transitions:
  - MANUAL → AUTO on the edge where debounced modo_auto is 1.
  - AUTO → MANUAL on the edge where debounced modo_auto is 0.
- MANUAL:
  - Each edge: {entradaA,entradaB} <= {stable_a,stable_b}; indice mirrors the same pair.
  - Total latency from raw switch change to output: DEBOUNCE_CYCLES+3 edges.
- AUTO:
  - On entry: indice=0, outputs=00, dwell counter=0.
  - The dwell counter counts 0..DWELL_CYCLES-1. At terminal count it wraps to 0 and indice increments mod 4 (11→00 wraps).
  - Outputs are {entradaA,entradaB}=indice.
  - Each row is held exactly DWELL_CYCLES cycles.
  - Switch values are ignored but are still debounced.
- Leaving AUTO:
  - The dwell counter clears.
  - Outputs take the debounced switches on the same edge the state changes.
  - Re-entering AUTO always restarts at row 00.
- cambio:
  - Registered comparison of the new output pair against the previous one.
  - High for exactly one cycle per change; never high in consecutive cycles unless the outputs change on consecutive edges.
  - Never high out of reset.
- Simultaneous events:
  - A mode change on the same edge as a dwell terminal count: the mode change wins and indice is not incremented.
  - sw_a and sw_b debounce independently, so they may update on different edges.
- Width rules: all counters are unsigned and saturate nowhere. Only indice wraps.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all raw inputs at 1 → entradaA, entradaB, indice, modo and cambio stay 0; after release, entradaA=1 exactly at edge 7.
- Debounce: MANUAL, toggle sw_a 0→1→0 with 3-cycle glitches, then hold 1 → entradaA stays 0 through the glitches and rises 7 edges after the final settle; cambio pulses once.
- Manual pair: set sw_a=1, sw_b=0 stable → outputs 10 and indice=2 after 7 edges; then sw_b=1 → outputs 11, indice=3, one more cambio pulse.
- AUTO sweep: modo_auto=1 → modo=1, outputs 00; then 01, 10, 11, 00 in 5-cycle steps; cambio pulses 4 times per full wrap.
- Mode exit mid-row: in AUTO at row 10 (dwell count 2), drop modo_auto with switches at 01 → exactly 7 edges later modo=0 and outputs=01; re-enter AUTO → restarts at 00 with full 5-cycle dwell.
- Reset mid-AUTO at row 11 → next edge all outputs 0, modo=0; no cambio pulse.
